// File: rtl/fixed_dot_acc.sv
// fixed_dot_acc: pipelined signed fixed-point dot-product accumulator.
// Each accepted beat forms LANES products. The products are reduced by a
// registered adder tree and then summed into a wide accumulator. A result is
// emitted only on the beat flagged in_last.
// Optional feature macro: FIXED_DOT_SAT_EN. When it is defined, the result
// saturates and out_sat is set on a clip. When it is undefined, the result
// wraps and out_sat is held at 0.
module fixed_dot_acc #(
  parameter int TOTAL_PREC = 27,
  parameter int FRAC_BITS  = 22,
  parameter int LANES      = 3,
  parameter int ACC_GUARD  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [TOTAL_PREC*LANES-1:0]   a,
  input  logic [TOTAL_PREC*LANES-1:0]   b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TOTAL_PREC-1:0]         res,
  output logic                          out_sat
);

  localparam int FW = 2 * TOTAL_PREC;              // full product width
  localparam int PW = FW - FRAC_BITS;              // lane result width
  localparam int T  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int TW = PW + T;                      // tree output width
  localparam int AW = TW + ACC_GUARD;              // accumulator width

  // Number of live nodes feeding the given tree level.
  function automatic int node_count(input int level);
    return (LANES + (1 << level) - 1) >> level;
  endfunction

  // The whole pipeline moves together. It freezes only when a finished result
  // is still waiting to be taken.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage S0 registers: input capture.
  logic                        s0_valid;
  logic                        s0_last;
  logic [TOTAL_PREC*LANES-1:0] s0_a;
  logic [TOTAL_PREC*LANES-1:0] s0_b;

  // Capture the offered beat. in_ready equals adv, so an accepted beat is
  // exactly in_valid at an advancing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else if (adv) begin
      s0_valid <= in_valid;
      s0_last  <= in_last;
      s0_a     <= a;
      s0_b     <= b;
    end
  end

  // Per-lane products. The operands are sign-extended to full width first so
  // that no product bits are lost. The arithmetic shift truncates toward -inf.
  logic [LANES*PW-1:0] lane_prod;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [TOTAL_PREC-1:0] op_a;
      logic signed [TOTAL_PREC-1:0] op_b;
      logic signed [FW-1:0]         full;
      assign op_a = s0_a[gi*TOTAL_PREC +: TOTAL_PREC];
      assign op_b = s0_b[gi*TOTAL_PREC +: TOTAL_PREC];
      assign full = FW'(op_a) * FW'(op_b);
      assign lane_prod[gi*PW +: PW] = PW'(full >>> FRAC_BITS);
    end
  endgenerate

  // Tree storage. Level 0 holds the registered lane products (stage S1).
  // The second dimension is doubled so that a pair read (2j, 2j+1) never
  // leaves the array. The entries above LANES stay at their reset value of
  // zero.
  logic signed [TW-1:0] node [0:T][0:2*LANES-1];
  logic [T:0]           tree_valid;
  logic [T:0]           tree_last;

  // S1 product registers, plus the T adder-tree levels. At each level an odd
  // node is passed through unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_valid <= '0;
      tree_last  <= '0;
      for (int l = 0; l <= T; l++) begin
        for (int j = 0; j < 2*LANES; j++) begin
          node[l][j] <= '0;
        end
      end
    end else if (adv) begin
      tree_valid[0] <= s0_valid;
      tree_last[0]  <= s0_last;
      for (int j = 0; j < LANES; j++) begin
        node[0][j] <= TW'($signed(lane_prod[j*PW +: PW]));
      end
      for (int l = 1; l <= T; l++) begin
        tree_valid[l] <= tree_valid[l-1];
        tree_last[l]  <= tree_last[l-1];
        for (int j = 0; j < LANES; j++) begin
          if (2*j + 1 < node_count(l-1)) begin
            node[l][j] <= node[l-1][2*j] + node[l-1][2*j+1];
          end else if (2*j < node_count(l-1)) begin
            node[l][j] <= node[l-1][2*j];
          end else begin
            node[l][j] <= '0;
          end
        end
      end
    end
  end

  // Accumulator and the narrowing of the running sum.
  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         acc_next;
  logic [TOTAL_PREC-1:0]        res_next;

  assign acc_next = acc + AW'(node[T][0]);

`ifdef FIXED_DOT_SAT_EN
  localparam logic signed [AW-1:0] RES_MAX = AW'((64'sd1 <<< (TOTAL_PREC-1)) - 64'sd1);
  localparam logic signed [AW-1:0] RES_MIN = ~RES_MAX;

  logic sat_next;

  // Clip to the representable result range, and flag the clip.
  always_comb begin
    res_next = acc_next[TOTAL_PREC-1:0];
    sat_next = 1'b0;
    if (acc_next > RES_MAX) begin
      res_next = RES_MAX[TOTAL_PREC-1:0];
      sat_next = 1'b1;
    end else if (acc_next < RES_MIN) begin
      res_next = RES_MIN[TOTAL_PREC-1:0];
      sat_next = 1'b1;
    end
  end

  // The saturation flag is loaded together with res and held with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (adv && tree_valid[T] && tree_last[T]) begin
      out_sat <= sat_next;
    end
  end
`else
  // Wrap: keep the low TOTAL_PREC bits of the running sum.
  always_comb begin
    res_next = acc_next[TOTAL_PREC-1:0];
  end

  assign out_sat = 1'b0;
`endif

  // Accumulate or emit. A last beat loads the output register and restarts the
  // sum from zero. A bubble leaves acc alone. A result that is consumed with
  // nothing behind it drops out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      res       <= '0;
    end else if (adv) begin
      out_valid <= tree_valid[T] && tree_last[T];
      if (tree_valid[T]) begin
        if (tree_last[T]) begin
          res <= res_next;
          acc <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_dot_acc.sv
// tb_fixed_dot_acc: scoreboard bench for fixed_dot_acc with default parameters.
// Expected {sat,res} pairs are queued when a last beat is driven. They are
// popped and compared whenever the DUT hands over a result.
module tb_fixed_dot_acc;
  localparam int TP    = 27;
  localparam int LANES = 3;
  localparam int FB    = 22;
  localparam int ONE   = 32'h400000;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [TP*LANES-1:0] a;
  logic [TP*LANES-1:0] b;
  logic               out_valid;
  logic               out_ready;
  logic [TP-1:0]      res;
  logic               out_sat;

  always #5 clk = ~clk;

  fixed_dot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .out_sat   (out_sat)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [TP:0] exp_q [$];
  longint      model_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [TP*LANES-1:0] pk(input int x0, input int x1, input int x2);
    return {TP'(x2), TP'(x1), TP'(x0)};
  endfunction

  function automatic logic [TP*LANES-1:0] rand_vec();
    return {TP'($urandom), TP'($urandom), TP'($urandom)};
  endfunction

  // Reference dot product: exact products, each floored by 2^FB.
  function automatic longint lane_dot(input logic [TP*LANES-1:0] av, input logic [TP*LANES-1:0] bv);
    longint s;
    longint pa;
    longint pb;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      pa = longint'($signed(av[i*TP +: TP]));
      pb = longint'($signed(bv[i*TP +: TP]));
      s += (pa * pb) >>> FB;
    end
    return s;
  endfunction

  function automatic logic [TP:0] conv(input longint v);
    logic [63:0] u;
    u = v;
`ifdef FIXED_DOT_SAT_EN
    if (v > 64'sd67108863) return {1'b1, 27'h3FFFFFF};
    if (v < -64'sd67108864) return {1'b1, 27'h4000000};
`endif
    return {1'b0, u[TP-1:0]};
  endfunction

  // Drive one beat and hold it until it is accepted. A last beat queues either
  // the model result or the explicit constant that the caller supplies.
  task automatic drive_beat(input logic [TP*LANES-1:0] av, input logic [TP*LANES-1:0] bv,
                            input bit last, input bit has_exp = 1'b0,
                            input logic [TP:0] exp_v = '0);
    bit accepted;
    int guard;
    model_acc += lane_dot(av, bv);
    if (last) begin
      exp_q.push_back(has_exp ? exp_v : conv(model_acc));
      model_acc = 0;
    end
    a = av; b = bv; in_last = last; in_valid = 1'b1;
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("accept", accepted, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each handshake, and checks that a
  // stalled result is held.
  logic        prev_stall = 1'b0;
  logic [TP-1:0] prev_res = '0;
  logic        prev_sat = 1'b0;
  logic [TP:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_res", res, prev_res);
        chk("hold_sat", out_sat, prev_sat);
      end
      if (out_valid && out_ready) begin
        chk("exp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res", res, e[TP-1:0]);
          chk("sat", out_sat, e[TP]);
          $display("result %0d: res=0x%0h sat=%0d", n_out, res, out_sat);
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
      prev_sat   = out_sat;
    end
  end

  int o0;
  int lat;
  int len;
  bit saw_stall;
  bit rnd_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat: 1*1 + 2*1 + (-0.5)*2 = 2.0, five cycles after acceptance.
    o0 = n_out;
    drive_beat(pk(ONE, 2*ONE, -ONE/2), pk(ONE, ONE, 2*ONE), 1'b1, 1'b1, {1'b0, 27'h0800000});
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 5);
    drain();
    chk("single_pulses", n_out - o0, 1);

    // Two-beat chain of 1.0s gives 6.0, with a single output.
    o0 = n_out;
    drive_beat(pk(ONE, ONE, ONE), pk(ONE, ONE, ONE), 1'b0);
    drive_beat(pk(ONE, ONE, ONE), pk(ONE, ONE, ONE), 1'b1, 1'b1, {1'b0, 27'h1800000});
    drain();
    chk("chain_pulses", n_out - o0, 1);

    // Overflow: 3 * 16.0 = 48.0.
`ifdef FIXED_DOT_SAT_EN
    drive_beat(pk(4*ONE, 4*ONE, 4*ONE), pk(4*ONE, 4*ONE, 4*ONE), 1'b1, 1'b1, {1'b1, 27'h3FFFFFF});
`else
    drive_beat(pk(4*ONE, 4*ONE, 4*ONE), pk(4*ONE, 4*ONE, 4*ONE), 1'b1, 1'b1, {1'b0, 27'h4000000});
`endif
    drain();

    // Truncation toward -inf: (-1 LSB) * 0.5 gives -1 LSB.
    drive_beat(pk(-1, 0, 0), pk(ONE/2, 0, 0), 1'b1, 1'b1, {1'b0, 27'h7FFFFFF});
    drain();

    // Back-pressure: eight vectors while the output is blocked for 10 cycles.
    o0 = n_out;
    saw_stall = 1'b0;
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          drive_beat(pk(k*ONE, 0, 0), pk(ONE, 0, 0), 1'b1, 1'b1, {1'b0, TP'(k*ONE)});
        end
      end
      begin
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_in_ready_fell", saw_stall, 1);
    drain();
    chk("bp_count", n_out - o0, 8);

    // Reset mid-chain: the partial sum is discarded.
    drive_beat(pk(ONE, ONE, ONE), pk(ONE, ONE, ONE), 1'b0);
    drive_beat(pk(ONE, ONE, ONE), pk(ONE, ONE, ONE), 1'b0);
    rst = 1'b1;
    model_acc = 0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_beat(pk(ONE, 0, 0), pk(3*ONE, 0, 0), 1'b1, 1'b1, {1'b0, 27'h0C00000});
    drain();

    // Random chains with a random output stall pattern.
    rnd_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 20; v++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            drive_beat(rand_vec(), rand_vec(), k == len - 1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_dot_acc.md
# fixed_dot_acc

Pipelined, parametrised fixed-point dot-product engine for the svrender transform and shading path. Each accepted beat multiplies LANES pairs of signed fixed-point operands, reduces them through a registered adder tree, and adds the sum into a wide accumulator. A result is emitted only on the beat flagged `in_last`, so vectors longer than LANES are handled as multi-beat chains. Valid/ready handshaking on both sides gives full back-pressure with no data loss.

## Interface
- `TOTAL_PREC`, 27: operand and result width, two's complement.
- `FRAC_BITS`, 22: fractional bits. 1.0 = 2^FRAC_BITS.
- `LANES`, 3: products per beat, ≥1.
- `ACC_GUARD`, 4: extra accumulator MSBs beyond the tree width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_last` in 1: final beat of a vector.
- `a` in TOTAL_PREC×LANES: signed operand array.
- `b` in TOTAL_PREC×LANES: signed operand array.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `res` out TOTAL_PREC: signed result.
- `out_sat` out 1: result was clipped. Constant 0 without the macro.

## Operation
- Global advance: `adv = !out_valid || out_ready`. `in_ready = adv`. When `adv` is 0, every stage holds, including valid bits.
- S0: register `a`, `b`, `in_last`, and valid.
- S1: each lane computes the full 2·TOTAL_PREC product, then arithmetic-shifts it right by FRAC_BITS (truncation toward −∞). The lane result is kept at PW = 2·TOTAL_PREC−FRAC_BITS bits and registered.
- Tree: the adder tree has T = clog2(LANES) registered levels (T = 0 when LANES = 1). Width grows by 1 bit per level. An odd operand passes through a register.
- ACC stage: `acc_next = acc + tree_sum`. The accumulator is PW+T+ACC_GUARD bits wide.
  - On a valid last beat: load the output register from `acc_next` and clear `acc` to 0.
  - On a valid non-last beat: `acc <= acc_next` and produce no output.
- Output conversion: narrow `acc_next` to TOTAL_PREC bits, by saturating or wrapping (see Configuration).
- Bubbles (valid = 0) pass through without touching `acc`.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset values: `in_ready` = 1 combinationally after reset (since `out_valid` = 0); `out_valid` = 0; `res` = 0; `out_sat` = 0. All pipeline valids and `acc` are 0.
- Latency: L = 3 + T cycles from acceptance of a last beat to `out_valid`, with no stall. With LANES = 3, L = 5.
- Throughput is one beat per cycle while `out_ready` = 1.
- `res` and `out_sat` are stable while `out_valid && !out_ready`.
- Simultaneous `out_ready` = 1 with a new result arriving: the old result is consumed and the new one loaded in the same cycle.
- Reset mid-chain: partial sums and in-flight beats are discarded. The next vector starts from `acc` = 0.
- `in_last` = 1 on a single beat gives a plain LANES-wide dot product.

## Configuration
- `FIXED_DOT_SAT_EN` defined:
  - If `acc_next` > 2^(TOTAL_PREC−1)−1, `res` = max and `out_sat` = 1.
  - If `acc_next` < −2^(TOTAL_PREC−1), `res` = min and `out_sat` = 1.
  - Otherwise `res` is exact and `out_sat` = 0.
- Not defined: `res` = the low TOTAL_PREC bits of `acc_next` (wrap), and `out_sat` is tied to 0.

## Test plan
All scenarios use the default parameters (TOTAL_PREC = 27, FRAC_BITS = 22, LANES = 3); 1.0 = 0x400000.
- Single beat: a = {1.0, 2.0, −0.5}, b = {1.0, 1.0, 2.0}, `in_last` = 1 → `res` = 0x800000 (2.0) exactly 5 cycles later, one `out_valid` pulse, `out_sat` = 0.
- Chain: two beats a = b = {1.0, 1.0, 1.0}, last = 0 then 1 → a single output `res` = 0x1800000 (6.0), with no output for the first beat.
- Overflow: a = b = {4.0, 4.0, 4.0} (sum 48.0), single beat.
  - With macro: `res` = 0x3FFFFFF and `out_sat` = 1.
  - Without macro: `res` = 0x4000000 (−16.0) and `out_sat` = 0.
- Back-pressure: stream 8 single-beat vectors a = {k·1.0, 0, 0}, b = {1.0, 0, 0} for k = 1..8, holding `out_ready` = 0 for 10 cycles → `in_ready` falls, then results 1.0..8.0 emerge in order, none lost or repeated.
- Reset mid-chain: two beats of 1.0s with last = 0, pulse `rst`, then one beat a = {1.0, 0, 0}, b = {3.0, 0, 0}, last = 1 → `res` = 0xC00000 (3.0).
- Truncation: a = {−1 LSB, 0, 0}, b = {0.5, 0, 0}, last = 1 → `res` = 0x7FFFFFF (−1 LSB, rounded toward −∞).
